// File: rtl/gate_model_tester_pkg.sv
// rtl/gate_model_tester_pkg.sv - shared widths, tap positions, FSM states and MISR step for the gate-model tester
package gate_model_tester_pkg;

    localparam int IN_W  = 20;
    localparam int OUT_W = 10;

    localparam int LFSR_TAP_HI = 19;
    localparam int LFSR_TAP_LO = 16;
    localparam int MISR_TAP_HI = 9;
    localparam int MISR_TAP_LO = 6;

    // An all-zero LFSR state never advances, so a zero seed is replaced by this.
    localparam logic [IN_W-1:0] SEED_DEFAULT = 20'h00001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_CAPTURE,
        ST_DONE
    } state_e;

    function automatic logic [OUT_W-1:0] misr_next(input logic [OUT_W-1:0] m,
                                                   input logic [OUT_W-1:0] d);
        return {m[OUT_W-2:0], m[MISR_TAP_HI] ^ m[MISR_TAP_LO]} ^ d;
    endfunction

endpackage

// File: rtl/gmt_lfsr.sv
// rtl/gmt_lfsr.sv - 20-bit Fibonacci stimulus LFSR with seed load and single-step control
module gmt_lfsr
    import gate_model_tester_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            step_i,
    input  logic [IN_W-1:0] seed_i,
    output logic [IN_W-1:0] q_o
);

    logic [IN_W-1:0] q_q;
    logic [IN_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = (seed_i == '0) ? SEED_DEFAULT : seed_i;
        end else if (step_i) begin
            q_d = {q_q[IN_W-2:0], q_q[LFSR_TAP_HI] ^ q_q[LFSR_TAP_LO]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/gate_model_tester.sv
// rtl/gate_model_tester.sv - drives LFSR patterns into a gate model and compacts its responses into a MISR signature
module gate_model_tester
    import gate_model_tester_pkg::*;
#(
    parameter int SETTLE = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IN_W-1:0]  seed,
    input  logic [CNT_W-1:0] n_pat,
    input  logic [OUT_W-1:0] golden,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [OUT_W-1:0] signature,
    output logic [CNT_W-1:0] pat_idx
);

    localparam logic [3:0] SETTLE_M1 = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
    // With no settle time a freshly applied pattern is captured on the very next cycle.
    localparam state_e ST_APPLIED = (SETTLE == 0) ? ST_CAPTURE : ST_SETTLE;

    state_e           state_q, state_d;
    logic [IN_W-1:0]  seed_q;
    logic [CNT_W-1:0] n_pat_q;
    logic [OUT_W-1:0] golden_q;
    logic [OUT_W-1:0] misr_q, misr_d;
    logic [CNT_W-1:0] pat_idx_q, pat_idx_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             pass_q, pass_d;
    logic             latch_args;
    logic             lfsr_load;
    logic             lfsr_step;

    gmt_lfsr u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load_i(lfsr_load),
        .step_i(lfsr_step),
        .seed_i(seed_q),
        .q_o   (dut_in)
    );

    always_comb begin
        state_d    = state_q;
        misr_d     = misr_q;
        pat_idx_d  = pat_idx_q;
        cnt_d      = cnt_q;
        pass_d     = pass_q;
        latch_args = 1'b0;
        lfsr_load  = 1'b0;
        lfsr_step  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    latch_args = 1'b1;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                lfsr_load = 1'b1;
                misr_d    = '0;
                pat_idx_d = '0;
                pass_d    = 1'b0;
                cnt_d     = SETTLE_M1;
                if (n_pat_q == '0) begin
                    pass_d  = (golden_q == '0);
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_APPLIED;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_CAPTURE: begin
                misr_d = misr_next(misr_q, dut_out);
                if (pat_idx_q == n_pat_q - CNT_W'(1)) begin
                    pass_d  = (misr_d == golden_q);
                    state_d = ST_DONE;
                end else begin
                    lfsr_step = 1'b1;
                    pat_idx_d = pat_idx_q + CNT_W'(1);
                    cnt_d     = SETTLE_M1;
                    state_d   = ST_APPLIED;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            seed_q    <= '0;
            n_pat_q   <= '0;
            golden_q  <= '0;
            misr_q    <= '0;
            pat_idx_q <= '0;
            cnt_q     <= '0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            misr_q    <= misr_d;
            pat_idx_q <= pat_idx_d;
            cnt_q     <= cnt_d;
            pass_q    <= pass_d;
            if (latch_args) begin
                seed_q   <= seed;
                n_pat_q  <= n_pat;
                golden_q <= golden;
            end
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign pass      = pass_q;
    assign signature = misr_q;
    assign pat_idx   = pat_idx_q;

endmodule

// File: tb/tb_gate_model_tester.sv
// tb/tb_gate_model_tester.sv - randomized and directed self-checking bench for gate_model_tester
module tb_gate_model_tester;

    localparam int S     = 2;
    localparam int CNT_W = 16;
    localparam int MAXP  = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [19:0]      seed;
    logic [CNT_W-1:0] n_pat;
    logic [9:0]       golden;
    logic [19:0]      dut_in;
    logic [9:0]       dut_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [9:0]       signature;
    logic [CNT_W-1:0] pat_idx;

    int n_checks = 0;
    int n_fail   = 0;
    int gm_mode  = 0;

    gate_model_tester #(.SETTLE(S), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .seed     (seed),
        .n_pat    (n_pat),
        .golden   (golden),
        .dut_in   (dut_in),
        .dut_out  (dut_out),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .signature(signature),
        .pat_idx  (pat_idx)
    );

    always #5 clk = ~clk;

    // Stand-in gate models: loopback, stuck-high, and a fold of the upper bits.
    function automatic logic [9:0] resp(input int mode, input logic [19:0] d);
        case (mode)
            0:       return d[9:0];
            1:       return 10'h3FF;
            default: return d[19:10] ^ {d[0], d[9:1]};
        endcase
    endfunction

    assign dut_out = resp(gm_mode, dut_in);

    function automatic logic [19:0] lfsr_next(input logic [19:0] q);
        return {q[18:0], q[19] ^ q[16]};
    endfunction

    function automatic logic [9:0] misr_step(input logic [9:0] m, input logic [9:0] d);
        return {m[8:0], m[9] ^ m[6]} ^ d;
    endfunction

    function automatic logic [9:0] model_sig(input logic [19:0] sd, input int n, input int mode);
        logic [19:0] p;
        logic [9:0]  m;
        p = (sd == 20'h0) ? 20'h00001 : sd;
        m = '0;
        for (int k = 0; k < n; k++) begin
            m = misr_step(m, resp(mode, p));
            p = lfsr_next(p);
        end
        return m;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: expected outputs per cycle of a run, derived from pattern slots of S+1 cycles.
    int          m_run = 0;
    int          m_j, m_n, m_ldone;
    logic [19:0] m_pats [MAXP];
    logic [9:0]  m_sig  [MAXP+1];
    logic [9:0]  m_gold;
    logic [19:0] h_din  = '0;
    logic [9:0]  h_sig  = '0;
    logic        h_pass = 1'b0;
    int          h_idx  = 0;

    always @(negedge clk) begin
        int p, pi, si;
        if (rst) begin
            chk("rst_busy", 32'(busy), 32'(1'b0));
            chk("rst_done", 32'(done), 32'(1'b0));
            chk("rst_dut_in", 32'(dut_in), 32'(20'h0));
            chk("rst_sig", 32'(signature), 32'(10'h0));
            chk("rst_pass", 32'(pass), 32'(1'b0));
            chk("rst_pat_idx", 32'(pat_idx), 32'(16'h0));
            m_run = 0; h_din = '0; h_sig = '0; h_pass = 1'b0; h_idx = 0;
        end else if (m_run != 0) begin
            chk("run_busy", 32'(busy), 32'(1'b1));
            chk("run_done", 32'(done), 32'(m_j == m_ldone));
            pi = 0;
            if (m_j == 0) begin
                chk("load_dut_in", 32'(dut_in), 32'(h_din));
                chk("load_sig", 32'(signature), 32'(h_sig));
                chk("load_pass", 32'(pass), 32'(h_pass));
                chk("load_pat_idx", 32'(pat_idx), h_idx);
            end else begin
                p  = (m_j - 1) / (S + 1);
                pi = (m_n == 0) ? 0 : ((p > m_n - 1) ? m_n - 1 : p);
                si = (p > m_n) ? m_n : p;
                chk("run_dut_in", 32'(dut_in), 32'(m_pats[pi]));
                chk("run_pat_idx", 32'(pat_idx), pi);
                chk("run_sig", 32'(signature), 32'(m_sig[si]));
                chk("run_pass", 32'(pass), 32'((m_j == m_ldone) && (m_sig[m_n] == m_gold)));
            end
            if (m_j == m_ldone) begin
                m_run  = 0;
                h_din  = m_pats[pi];
                h_idx  = pi;
                h_sig  = m_sig[m_n];
                h_pass = (m_sig[m_n] == m_gold);
            end else begin
                m_j++;
            end
        end else begin
            chk("idle_busy", 32'(busy), 32'(1'b0));
            chk("idle_done", 32'(done), 32'(1'b0));
            chk("idle_dut_in", 32'(dut_in), 32'(h_din));
            chk("idle_sig", 32'(signature), 32'(h_sig));
            chk("idle_pass", 32'(pass), 32'(h_pass));
            chk("idle_pat_idx", 32'(pat_idx), h_idx);
            if (start) begin
                m_n     = int'(n_pat);
                m_gold  = golden;
                m_ldone = 1 + m_n * (S + 1);
                m_pats[0] = (seed == 20'h0) ? 20'h00001 : seed;
                for (int k = 1; k < m_n; k++) m_pats[k] = lfsr_next(m_pats[k-1]);
                m_sig[0] = '0;
                for (int k = 0; k < m_n; k++) m_sig[k+1] = misr_step(m_sig[k], resp(gm_mode, m_pats[k]));
                m_j   = 0;
                m_run = 1;
            end
        end
    end

    task automatic run(input logic [19:0] sd, input int n, input logic [9:0] gold, input int mode,
                       input bit lit, input int e_lat, input logic [9:0] e_sig, input logic e_pass,
                       input int e_idx, input bit extra_start);
        int e;
        int extra;
        @(posedge clk); #2;
        gm_mode = mode; seed = sd; n_pat = CNT_W'(n); golden = gold; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        e = 0;
        forever begin
            @(negedge clk);
            if (done || e > 2000) break;
            @(posedge clk);
            e++;
            #2;
            start = extra_start && (e == 2);
        end
        start = 1'b0;
        if (e > 2000) begin
            chk("done_timeout", 32'(e), 32'(0));
        end else if (lit) begin
            chk("lit_latency", 32'(e + 1), 32'(e_lat));
            chk("lit_sig", 32'(signature), 32'(e_sig));
            chk("lit_pass", 32'(pass), 32'(e_pass));
            chk("lit_pat_idx", 32'(pat_idx), 32'(e_idx));
        end
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk("single_done", 32'(extra), 32'(0));
    endtask

    initial begin
        int n;
        int mode;
        logic [19:0] sd;
        logic [9:0]  gold;
        int dn;
        rst = 1'b1; start = 1'b0; seed = '0; n_pat = '0; golden = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        run(20'h00001, 1, 10'h001, 0, 1, 5,  10'h001, 1'b1, 0, 0);
        run(20'h00001, 2, 10'h000, 0, 1, 8,  10'h000, 1'b1, 1, 0);
        run(20'h00000, 1, 10'h001, 0, 1, 5,  10'h001, 1'b1, 0, 0);
        run(20'h12345, 0, 10'h000, 0, 1, 2,  10'h000, 1'b1, 0, 0);
        run(20'h12345, 0, 10'h3FF, 0, 1, 2,  10'h000, 1'b0, 0, 0);
        run(20'h00ABC, 3, 10'h000, 1, 1, 11, 10'h3FD, 1'b0, 2, 0);
        run(20'h00001, 2, 10'h000, 0, 1, 8,  10'h000, 1'b1, 1, 1);

        // Abort a run while it is settling its first pattern.
        @(posedge clk); #2;
        gm_mode = 0; seed = 20'h00005; n_pat = CNT_W'(3); golden = '0; start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        @(posedge clk); #2 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'(1'b0));
        chk("abort_done", 32'(done), 32'(1'b0));
        chk("abort_dut_in", 32'(dut_in), 32'(20'h0));
        chk("abort_sig", 32'(signature), 32'(10'h0));
        chk("abort_pass", 32'(pass), 32'(1'b0));
        chk("abort_pat_idx", 32'(pat_idx), 32'(16'h0));
        @(posedge clk); #2 rst = 1'b0;
        dn = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("abort_no_done", 32'(dn), 32'(0));

        for (int it = 0; it < 30; it++) begin
            mode = int'($urandom_range(0, 2));
            sd   = ($urandom_range(0, 5) == 0) ? 20'h0 : 20'($urandom);
            n    = int'($urandom_range(0, 8));
            gold = ($urandom_range(0, 1) == 0) ? model_sig(sd, n, mode) : 10'($urandom);
            run(sd, n, gold, mode, 0, 0, 10'h0, 1'b0, 0, ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
